// File: rtl/chaos_frame_tx.sv
// UART 8N1 framer for chaotic oscillator samples: header, x/y/z bytes MSB first, XOR checksum.
// Samples that arrive while a frame is in flight are dropped and counted (saturating).
//
// state | meaning
// IDLE  | line idle high, waiting for valid_i
// START | start bit (0) of the current byte
// DATA  | 8 data bits, LSB first
// STOP  | stop bit (1); then the next byte or IDLE
module chaos_frame_tx #(
    parameter int          Width   = 32,
    parameter int          BaudDiv = 434,
    parameter logic [7:0]  Header  = 8'hA5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [Width-1:0] xn_i,
    input  logic [Width-1:0] yn_i,
    input  logic [Width-1:0] zn_i,
    output logic             tx_o,
    output logic             busy_o,
    output logic [15:0]      drop_cnt_o
);

    localparam int NB = Width / 8;
    localparam int FL = 3 * NB + 2;
    localparam int CW = (BaudDiv > 2) ? $clog2(BaudDiv) : 1;
    localparam int BW = $clog2(FL);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state, state_next;
    logic [CW-1:0]      baud_cnt;
    logic [2:0]         bit_idx;
    logic [BW-1:0]      byte_idx;
    logic [7:0]         cur;
    logic [3*Width-1:0] payload;
    logic [3*Width-1:0] sample;
    logic [7:0]         chk;
    logic [7:0]         chk_in;
    logic               baud_end;
    logic               tx_next;
    logic               accept;
    logic               load_next;
    logic               shift_bit;

    assign baud_end = (baud_cnt == CW'(BaudDiv - 1));
    assign sample   = {xn_i, yn_i, zn_i};

    // Checksum is formed from the inputs at capture, so it is ready long before its byte.
    always_comb begin
        chk_in = 8'h00;
        for (int k = 0; k < 3 * NB; k++) begin
            chk_in = chk_in ^ sample[8*k +: 8];
        end
    end

    always_comb begin
        state_next = state;
        tx_next    = 1'b1;
        accept     = 1'b0;
        load_next  = 1'b0;
        shift_bit  = 1'b0;
        case (state)
            IDLE: begin
                if (valid_i) begin
                    accept     = 1'b1;
                    state_next = START;
                    tx_next    = 1'b0;
                end
            end
            START: begin
                tx_next = 1'b0;
                if (baud_end) begin
                    state_next = DATA;
                    tx_next    = cur[0];
                end
            end
            DATA: begin
                tx_next = cur[0];
                if (baud_end) begin
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                        tx_next    = 1'b1;
                    end else begin
                        shift_bit = 1'b1;
                        tx_next   = cur[1];
                    end
                end
            end
            STOP: begin
                tx_next = 1'b1;
                if (baud_end) begin
                    if (byte_idx == BW'(FL - 1)) begin
                        state_next = IDLE;
                    end else begin
                        state_next = START;
                        tx_next    = 1'b0;
                        load_next  = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            tx_o       <= 1'b1;
            busy_o     <= 1'b0;
            drop_cnt_o <= 16'h0000;
            baud_cnt   <= '0;
            bit_idx    <= 3'd0;
            byte_idx   <= '0;
            cur        <= 8'h00;
            payload    <= '0;
            chk        <= 8'h00;
        end else begin
            tx_o   <= tx_next;
            busy_o <= (state_next != IDLE);

            if (valid_i && (state != IDLE) && (drop_cnt_o != 16'hFFFF)) begin
                drop_cnt_o <= drop_cnt_o + 16'd1;
            end

            if ((state == IDLE) || baud_end) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end

            if (state != DATA) begin
                bit_idx <= 3'd0;
            end else if (baud_end) begin
                bit_idx <= bit_idx + 3'd1;
            end

            if (accept) begin
                byte_idx <= '0;
                cur      <= Header;
                payload  <= sample;
                chk      <= chk_in;
            end else if (load_next) begin
                byte_idx <= byte_idx + 1'b1;
                payload  <= payload << 8;
                // The byte after the last coordinate byte is the checksum.
                if (byte_idx == BW'(FL - 2)) begin
                    cur <= chk;
                end else begin
                    cur <= payload[3*Width-1 -: 8];
                end
            end else if (shift_bit) begin
                cur <= cur >> 1;
            end
        end
    end

endmodule

// File: doc/chaos_frame_tx.md
Name: chaos_frame_tx

Overview:
- Consumes the (x, y, z) samples produced by the fixed-point chaotic oscillator cores and sends them off-chip for plotting.
- Serializes each sample as one framed UART 8N1 packet: header, coordinate bytes, checksum.
- Sits between the oscillator outputs, with its enable strobe as valid_i, and the board TX pin.
- Samples arriving while a frame is in flight are dropped and counted.

Parameters:
- Width, 32, coordinate width in bits; must be a multiple of 8 and >= 8; NB = Width/8 bytes per coordinate.
- BaudDiv, 434, clock cycles per UART bit (50 MHz / 115200); must be >= 2.
- Header, 8'hA5, first byte of every frame.

Ports:
- clk_i  input  1  system clock, rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- valid_i  input  1  one-cycle sample strobe; xn_i/yn_i/zn_i are valid while it is high.
- xn_i  input  Width  x coordinate, two's complement fixed point (passed through as raw bits).
- yn_i  input  Width  y coordinate.
- zn_i  input  Width  z coordinate.
- tx_o  output  1  UART serial line, idle high.
- busy_o  output  1  high while a frame is being transmitted.
- drop_cnt_o  output  16  count of samples dropped because busy; saturating.

Behaviour:
- Reset (rst_i low, asynchronous, takes effect immediately):
  - tx_o=1, busy_o=0, drop_cnt_o=0, FSM returns to IDLE.
  - Any partial frame is abandoned with no completion; after release, the next frame starts fresh.
- Frame format, FL = 3*NB+2 bytes (14 for Width=32):
  - Header.
  - x bytes MSB first, then y bytes MSB first, then z bytes MSB first.
  - CHK = XOR of all 3*NB coordinate bytes; Header is excluded.
- Byte format: start bit (0), 8 data bits LSB first, stop bit (1). Each bit holds tx_o constant for exactly BaudDiv cycles.
- Consecutive bytes are back-to-back: a start bit immediately follows the previous stop bit, with no idle gap inside a frame.
- Accept rule:
  - A rising edge with valid_i=1 and FSM in IDLE captures xn_i/yn_i/zn_i into shadow registers.
  - busy_o goes high and tx_o goes low (header start bit) on that same edge, i.e. visible in the cycle after valid_i.
  - Inputs are not sampled again until the frame completes.
- Drop rule:
  - valid_i=1 on an edge where the FSM is not IDLE increments drop_cnt_o by 1.
  - drop_cnt_o saturates at 16'hFFFF.
  - The frame in flight is unaffected.
  - A valid_i during the final cycle of the last stop bit is dropped, because the FSM is still in STOP.
- FSM states and transitions:
  - IDLE -> START on accept.
  - START -> DATA after BaudDiv cycles.
  - DATA -> STOP after 8 bits of BaudDiv cycles each.
  - STOP -> START (next byte) if byte index < FL-1, else -> IDLE.
  - A baud counter counts 0..BaudDiv-1; a bit index counts 0..7; a byte index counts 0..FL-1.
  - CHK accumulates during capture or on the fly, and is final before its byte is loaded.
- Timing:
  - Frame duration is exactly FL*10*BaudDiv cycles of busy_o high.
  - busy_o falls when the FSM enters IDLE.
  - Minimum accept-to-accept spacing is FL*10*BaudDiv+1 cycles.
- Outputs tx_o and busy_o are registered; no combinational path from inputs to outputs.
- Ports use the Width parameter throughout; no truncation or sign handling of coordinates.

Test Plan (BaudDiv=4, Width=32; frame = 560 cycles):
1. Reset/idle: hold rst_i low, then release with valid_i=0 for 100 cycles -> tx_o=1, busy_o=0, drop_cnt_o=0 throughout.
2. Basic frame: one valid_i pulse with x=32'h00100000, y=0, z=0 -> decoded bytes A5 00 10 00 00 00 00 00 00 00 00 00 00 10. Also check: tx_o low 1 cycle after the strobe, every bit exactly 4 cycles, busy_o high exactly 560 cycles.
3. Checksum and ordering: x=32'h12345678, y=32'h9ABCDEF0, z=32'h000000FF -> bytes A5 12 34 56 78 9A BC DE F0 00 00 00 FF FF, with each data byte LSB first on the line.
4. Drops:
   - valid_i pulses at accept+10 and accept+300 -> drop_cnt_o=2, and the first frame's bytes are unchanged.
   - A pulse on the last STOP cycle -> dropped (drop_cnt_o=3).
   - A pulse one cycle later -> a new frame starts.
   - Force drop_cnt_o to 16'hFFFE with two more drops -> it stays at 16'hFFFF.
5. Reset mid-frame: assert rst_i at cycle 200 of a frame -> tx_o=1 and busy_o=0 immediately, asynchronously. After release, a new valid_i yields a complete, correct 14-byte frame.
6. Back-to-back: pulse valid_i exactly at accept+561 (first legal cycle) for five samples -> five contiguous correct frames separated by 1 idle cycle, with drop_cnt_o=0.
